// File: rtl/serframe_gen.sv
// Multi-lane serial frame generator: per-lane PRBS / direct / slot-count / idle bit streams
// with a shared frame sync pulse on bit 0 of every FRAME_BITS-bit frame.
module serframe_gen #(
  parameter int unsigned LANES      = 1,
  parameter int unsigned FRAME_BITS = 256,
  parameter int unsigned SLOT_BITS  = 32,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic             sclk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [LANES-1:0] ddata,
  output logic [LANES-1:0] sdata,
  output logic             sfs,
  output logic [15:0]      frame_cnt,
  output logic [1:0]       mode_act
);

  localparam int unsigned BW = $clog2(FRAME_BITS);
  localparam int unsigned IW = $clog2(SLOT_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  localparam logic [1:0] MODE_PRBS   = 2'd0;
  localparam logic [1:0] MODE_DIRECT = 2'd1;
  localparam logic [1:0] MODE_COUNT  = 2'd2;
  localparam logic [1:0] MODE_IDLE   = 2'd3;

  function automatic logic [15:0] lane_seed(input int unsigned l);
    logic [15:0] s;
    s = SEED ^ 16'(l);
    return (s == '0) ? 16'h0001 : s;
  endfunction

  logic [BW-1:0]    r_bitcnt;
  logic [LANES-1:0] r_sdata;
  logic             r_sfs;
  logic [15:0]      r_frame_cnt;
  logic [1:0]       r_mode_act;
  logic [15:0]      r_lfsr [LANES];

  logic             w_first;
  logic             w_last;
  logic [1:0]       w_mode_eff;
  logic [31:0]      w_slot;
  logic [IW-1:0]    w_pos;
  logic [LANES-1:0] w_sdata_nxt;
  logic [15:0]      w_lfsr_nxt [LANES];

  assign w_first = (r_bitcnt == '0);
  assign w_last  = (r_bitcnt == LAST_BIT);
  // Bit 0 of a frame already uses the newly requested mode.
  assign w_mode_eff = w_first ? mode : r_mode_act;
  assign w_slot = 32'(r_bitcnt) / SLOT_BITS;
  assign w_pos  = IW'(32'(r_bitcnt) % SLOT_BITS);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic                 w_b;
    logic [SLOT_BITS-1:0] w_cword;
    logic [IW-1:0]        w_idx;

    assign w_cword = SLOT_BITS'(w_slot + 32'(l));
    assign w_idx   = IW'(SLOT_BITS - 1) - w_pos;
    assign w_lfsr_nxt[l] = {r_lfsr[l][14:0],
                            r_lfsr[l][15] ^ r_lfsr[l][13] ^ r_lfsr[l][12] ^ r_lfsr[l][10]};

    always_comb begin
      w_b = 1'b0;
      case (w_mode_eff)
        MODE_PRBS:   w_b = r_lfsr[l][15];
        MODE_DIRECT: w_b = ddata[l];
        MODE_COUNT:  w_b = w_cword[w_idx];
        MODE_IDLE:   w_b = 1'b0;
      endcase
    end

    assign w_sdata_nxt[l] = w_b;
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_bitcnt    <= '0;
      r_sdata     <= '0;
      r_sfs       <= 1'b0;
      r_frame_cnt <= '0;
      r_mode_act  <= MODE_PRBS;
      for (int unsigned l = 0; l < LANES; l++) r_lfsr[l] <= lane_seed(l);
    end else if (enable) begin
      r_sfs   <= w_first;
      r_sdata <= w_sdata_nxt;
      if (w_first) r_mode_act <= mode;
      if (w_last) begin
        r_bitcnt    <= '0;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_bitcnt <= r_bitcnt + BW'(1);
      end
      // LFSRs only advance on bits actually emitted as PRBS.
      if (w_mode_eff == MODE_PRBS)
        for (int unsigned l = 0; l < LANES; l++) r_lfsr[l] <= w_lfsr_nxt[l];
    end else begin
      r_sfs <= 1'b0;
    end
  end

  assign sdata     = r_sdata;
  assign sfs       = r_sfs;
  assign frame_cnt = r_frame_cnt;
  assign mode_act  = r_mode_act;

endmodule

// File: tb/tb_serframe_gen.sv
// Scoreboard bench for serframe_gen: driver pushes predicted outputs, monitor pops and compares.
module tb_serframe_gen;
  localparam int unsigned LANES = 2;
  localparam int unsigned FB    = 32;
  localparam int unsigned SB    = 8;

  typedef struct packed {
    logic [LANES-1:0] sd;
    logic             sfs;
    logic [15:0]      fc;
    logic [1:0]       ma;
  } exp_t;

  logic             sclk   = 1'b0;
  logic             rstn   = 1'b1;
  logic             enable = 1'b0;
  logic [1:0]       mode   = 2'd0;
  logic [LANES-1:0] ddata  = '0;
  logic [LANES-1:0] sdata;
  logic             sfs;
  logic [15:0]      frame_cnt;
  logic [1:0]       mode_act;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int               m_bc;
  logic [15:0]      m_lfsr [LANES];
  logic [15:0]      m_fc;
  logic [1:0]       m_ma;
  logic [LANES-1:0] m_sd;
  logic             m_sfs;

  always #5 sclk = ~sclk;

  serframe_gen #(.LANES(LANES), .FRAME_BITS(FB), .SLOT_BITS(SB), .SEED(16'hACE1)) dut (
    .sclk(sclk), .rstn(rstn), .enable(enable), .mode(mode), .ddata(ddata),
    .sdata(sdata), .sfs(sfs), .frame_cnt(frame_cnt), .mode_act(mode_act)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic en, input logic [1:0] md,
                            input logic [LANES-1:0] dd, output exp_t e);
    logic [7:0] w8;
    int pos;
    if (!r) begin
      m_bc = 0; m_fc = '0; m_ma = 2'd0; m_sd = '0; m_sfs = 1'b0;
      m_lfsr[0] = 16'hACE1;
      m_lfsr[1] = 16'hACE0;
    end else if (en) begin
      if (m_bc == 0) m_ma = md;
      m_sfs = (m_bc == 0);
      for (int l = 0; l < LANES; l++) begin
        case (m_ma)
          2'd0: begin
            m_sd[l] = m_lfsr[l][15];
            m_lfsr[l] = {m_lfsr[l][14:0],
                         m_lfsr[l][15] ^ m_lfsr[l][13] ^ m_lfsr[l][12] ^ m_lfsr[l][10]};
          end
          2'd1: m_sd[l] = dd[l];
          2'd2: begin
            w8  = 8'(m_bc / SB + l);
            pos = 7 - (m_bc % SB);
            m_sd[l] = w8[pos];
          end
          default: m_sd[l] = 1'b0;
        endcase
      end
      if (m_bc == FB - 1) m_fc = m_fc + 16'd1;
      m_bc = (m_bc + 1) % FB;
    end else begin
      m_sfs = 1'b0;
    end
    e = '{sd: m_sd, sfs: m_sfs, fc: m_fc, ma: m_ma};
  endtask

  // Drives one cycle's inputs, queues the prediction, returns at the following negedge.
  task automatic cyc(input logic r, input logic en, input logic [1:0] md, input logic [LANES-1:0] dd);
    exp_t e;
    rstn = r; enable = en; mode = md; ddata = dd;
    model_step(r, en, md, dd, e);
    q.push_back(e);
    @(negedge sclk);
  endtask

  task automatic run(input int n, input logic en, input logic [1:0] md);
    for (int i = 0; i < n; i++) cyc(1'b1, en, md, LANES'($urandom));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge sclk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sdata", 32'(sdata), 32'(e.sd));
        chk("sfs", 32'(sfs), 32'(e.sfs));
        chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
        chk("mode_act", 32'(mode_act), 32'(e.ma));
      end
    end
  end

  initial begin : driver
    logic [2:0]  pb;
    logic [31:0] c0, c1;
    pb = '0; c0 = '0; c1 = '0;

    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 2'd0, '1);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'h0);

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 2'd0, '0);
      pb[2-i] = sdata[0];
      if (i == 0) chk("first_sfs", 32'(sfs), 32'h1);
      if (i == 1) chk("second_sfs", 32'(sfs), 32'h0);
    end
    chk("prbs_first_bits", 32'(pb), 32'h5);
    run(FB - 3, 1'b1, 2'd0);
    chk("frame_cnt_1", 32'(frame_cnt), 32'h1);
    run(FB, 1'b1, 2'd0);
    chk("frame_cnt_2", 32'(frame_cnt), 32'h2);

    run(5, 1'b1, 2'd0);
    run(FB - 5, 1'b1, 2'd2);
    chk("mode_held_midframe", 32'(mode_act), 32'h0);

    for (int i = 0; i < FB; i++) begin
      cyc(1'b1, 1'b1, 2'd2, '0);
      c0 = {c0[30:0], sdata[0]};
      c1 = {c1[30:0], sdata[1]};
    end
    chk("count_lane0", c0, 32'h00010203);
    chk("count_lane1", c1, 32'h01020304);

    run(10, 1'b1, 2'd1);
    run(5, 1'b0, 2'd0);
    run(10, 1'b1, 2'd1);
    run(FB - 20, 1'b1, 2'd0);
    chk("direct_mode_act", 32'(mode_act), 32'h1);
    chk("frame_cnt_5", 32'(frame_cnt), 32'h5);

    run(FB, 1'b1, 2'd0);
    chk("prbs_after_direct", 32'(mode_act), 32'h0);

    run(12, 1'b1, 2'd3);
    cyc(1'b0, 1'b1, 2'd3, '1);
    cyc(1'b0, 1'b1, 2'd3, '1);
    chk("midframe_reset_cnt", 32'(frame_cnt), 32'h0);
    cyc(1'b1, 1'b1, 2'd2, '0);
    chk("sfs_after_reset", 32'(sfs), 32'h1);
    run(FB, 1'b1, 2'd2);
    chk("frame_cnt_after_reset", 32'(frame_cnt), 32'h1);

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge sclk);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
